// File: rtl/spi_master_pkg.sv
// Shared SPI master definitions: FSM state encoding, frame size and mode constants.
package spi_pkg;

    localparam int unsigned SPI_FRAME_BITS = 8;
    localparam logic        CPOL           = 1'b0;
    localparam logic        CPHA           = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        WAIT,
        HOLD,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_master_clkgen.sv
// SPI clock generator: half-period counter and sclk register, held at idle level while disabled.
// sclk_rise/sclk_fall flag the clk edge on which sclk changes, so callers act on the same edge.
import spi_pkg::*;

module spi_master_clkgen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [15:0] cnt;
    logic        wrap;

    assign wrap      = en && (cnt == 16'(CLK_DIV - 1));
    assign sclk_rise = wrap && (sclk == CPOL);
    assign sclk_fall = wrap && (sclk != CPOL);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt  <= '0;
            sclk <= CPOL;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode 0 master, MSB first, 8-bit frames, multi-byte transactions framed by tx_last.
// Define SPI_MASTER_LOOPBACK_EN to sample the registered mosi instead of the miso pin.
import spi_pkg::*;

module spi_master #(
    parameter int unsigned CLK_DIV  = 10,
    parameter int unsigned SS_SETUP = 4,
    parameter int unsigned SS_HOLD  = 4,
    parameter int unsigned SS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ss,
    output logic       mosi,
    input  logic       miso
);

    spi_state_t state;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    logic [7:0] cnt;
    logic       last_q;
    logic       clk_en;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       miso_s;
    logic       accept;

    assign clk_en = (state == XFER);
    assign accept = tx_valid && tx_ready;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_s = mosi;
`else
    assign miso_s = miso;
`endif

    spi_master_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (clk_en),
        .sclk     (sclk),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ss       <= 1'b1;
            mosi     <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            cnt      <= '0;
            last_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_sr    <= tx_data;
                        last_q   <= tx_last;
                        mosi     <= tx_data[7];
                        ss       <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        cnt      <= '0;
                        state    <= SETUP;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == 8'(SS_SETUP)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= XFER;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                XFER: begin
                    if (sclk_rise) begin
                        rx_sr <= {rx_sr[6:0], miso_s};
                    end
                    if (sclk_fall) begin
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        mosi    <= tx_sr[6];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(SPI_FRAME_BITS - 1)) begin
                            rx_data  <= rx_sr;
                            rx_valid <= 1'b1;
                            cnt      <= '0;
                            state    <= last_q ? HOLD : WAIT;
                        end
                    end
                end
                // tx_ready rises one cycle into WAIT so an accept never shares a cycle with rx_valid
                WAIT: begin
                    if (accept) begin
                        tx_sr    <= tx_data;
                        last_q   <= tx_last;
                        mosi     <= tx_data[7];
                        tx_ready <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= XFER;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'(SS_HOLD - 1)) begin
                        ss    <= 1'b1;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'(SS_IDLE - 1)) begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: mode 0 slave model on miso, pulse/edge monitor, hand-computed expectations.
`timescale 1ns/1ps

module tb_spi_master;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned SS_SETUP = 4;
    localparam int unsigned SS_HOLD  = 4;
    localparam int unsigned SS_IDLE  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       hold0 = 1'b0;

    spi_master #(
        .CLK_DIV (CLK_DIV),
        .SS_SETUP(SS_SETUP),
        .SS_HOLD (SS_HOLD),
        .SS_IDLE (SS_IDLE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .ss      (ss),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // mode 0 slave: presents MSB on ss fall, shifts on each sclk fall, reloads every 8 bits
    logic [7:0] slv_byte = 8'h00;
    logic [7:0] slv_sr = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    int slv_bits = 0;

    always @(negedge ss) begin
        slv_sr   = slv_byte;
        slv_bits = 0;
    end

    always @(negedge sclk) begin
        if (ss === 1'b0) begin
            slv_bits++;
            if (slv_bits == 8) begin
                slv_sr   = slv_byte;
                slv_bits = 0;
            end else begin
                slv_sr = slv_sr << 1;
            end
        end
    end

    always @(posedge sclk) mosi_cap = {mosi_cap[6:0], mosi};

    assign miso = hold0 ? 1'b0 : slv_sr[7];

    int n_rise, n_rxv, n_done, n_ssrise, first_rise, last_fall, done_cyc, mosi_unst, ss_run, last_ss_run;
    logic sclk_q = 1'b0, ss_q = 1'b1, mosi_q = 1'b0;
    logic [7:0] last_rx = 8'h00;

    always @(negedge clk) begin
        if (sclk === 1'b1 && sclk_q === 1'b0) begin
            n_rise++;
            if (first_rise < 0) first_rise = cyc;
            if (mosi !== mosi_q) mosi_unst++;
        end
        if (sclk === 1'b0 && sclk_q === 1'b1) last_fall = cyc;
        if (rx_valid === 1'b1) begin
            n_rxv++;
            last_rx = rx_data;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (ss === 1'b1 && ss_q === 1'b0) n_ssrise++;
        if (ss === 1'b1) begin
            ss_run++;
        end else begin
            if (ss_run > 0) last_ss_run = ss_run;
            ss_run = 0;
        end
        sclk_q = sclk;
        ss_q   = ss;
        mosi_q = mosi;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_rise = 0; n_rxv = 0; n_done = 0; n_ssrise = 0;
        first_rise = -1; last_fall = 0; done_cyc = 0; mosi_unst = 0;
        mosi_cap = 8'h00;
    endtask

    task automatic offer(input logic [7:0] d, input logic last);
        int n;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("accept_timeout", 32'(n >= 2000), 32'd0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    // which: 0 = done pulses, 1 = rx_valid pulses, 2 = sclk rises
    task automatic wait_cnt(input string tag, input int which, input int target);
        int n;
        int v;
        n = 0;
        v = (which == 0) ? n_done : (which == 1) ? n_rxv : n_rise;
        while (v < target && n < 3000) begin
            tick();
            n++;
            v = (which == 0) ? n_done : (which == 1) ? n_rxv : n_rise;
        end
        check(tag, 32'(n >= 3000), 32'd0);
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return slv;
`endif
    endfunction

    initial begin
        int n;
        int stall_bad;
        n_rise = 0; n_rxv = 0; n_done = 0; n_ssrise = 0; first_rise = -1;
        last_fall = 0; done_cyc = 0; mosi_unst = 0; ss_run = 0; last_ss_run = 0;

        repeat (3) tick();
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(tx_ready), 32'd1);

        // single byte, timing of first rise and done
        slv_byte = 8'h3C;
        clr_mon();
        offer(8'hA5, 1'b1);
        tx_valid = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        wait_cnt("t1_done_timeout", 0, 1);
        check("t1_rx", 32'(last_rx), 32'(exp_rx(8'hA5, 8'h3C)));
        check("t1_rxv_cnt", 32'(n_rxv), 32'd1);
        check("t1_mosi", 32'(mosi_cap), 32'hA5);
        check("t1_mosi_stable", 32'(mosi_unst), 32'd0);
        check("t1_first_rise", 32'(first_rise - acc_cyc), 32'd9);
        check("t1_done_lat", 32'(done_cyc - last_fall), 32'd4);
        check("t1_rises", 32'(n_rise), 32'd8);
        repeat (4) tick();
        check("t1_idle_busy", 32'(busy), 32'd0);

        // three bytes, tx_valid held high
        slv_byte = 8'h5A;
        clr_mon();
        offer(8'h01, 1'b0);
        offer(8'h80, 1'b0);
        offer(8'hFF, 1'b1);
        tx_valid = 1'b0;
        wait_cnt("t2_done_timeout", 0, 1);
        check("t2_rises", 32'(n_rise), 32'd24);
        check("t2_rxv_cnt", 32'(n_rxv), 32'd3);
        check("t2_done_cnt", 32'(n_done), 32'd1);
        check("t2_ss_rise", 32'(n_ssrise), 32'd1);
        check("t2_rx", 32'(last_rx), 32'(exp_rx(8'hFF, 8'h5A)));
        check("t2_mosi", 32'(mosi_cap), 32'hFF);
        repeat (4) tick();

        // upstream stall in WAIT
        slv_byte = 8'hE7;
        clr_mon();
        offer(8'h3A, 1'b0);
        tx_valid = 1'b0;
        wait_cnt("t3_rxv_timeout", 1, 1);
        check("t3_rx0", 32'(last_rx), 32'(exp_rx(8'h3A, 8'hE7)));
        check("t3_mosi0", 32'(mosi_cap), 32'h3A);
        tick();
        tick();
        stall_bad = 0;
        repeat (50) begin
            tick();
            if (ss !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
        end
        check("t3_stall", 32'(stall_bad), 32'd0);
        offer(8'hC5, 1'b1);
        tx_valid = 1'b0;
        wait_cnt("t3_done_timeout", 0, 1);
        check("t3_rx1", 32'(last_rx), 32'(exp_rx(8'hC5, 8'hE7)));
        check("t3_mosi1", 32'(mosi_cap), 32'hC5);
        check("t3_rxv_cnt", 32'(n_rxv), 32'd2);
        check("t3_ss_rise", 32'(n_ssrise), 32'd1);
        repeat (4) tick();

        // reset in the middle of a byte
        slv_byte = 8'hFF;
        clr_mon();
        offer(8'h55, 1'b1);
        tx_valid = 1'b0;
        wait_cnt("t4_rise_timeout", 2, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t4_ss", 32'(ss), 32'd1);
        check("t4_sclk", 32'(sclk), 32'd0);
        check("t4_mosi", 32'(mosi), 32'd0);
        check("t4_tx_ready", 32'(tx_ready), 32'd0);
        check("t4_rx_data", 32'(rx_data), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("t4_no_rxv", 32'(n_rxv), 32'd0);
        check("t4_no_done", 32'(n_done), 32'd0);
        slv_byte = 8'h81;
        clr_mon();
        offer(8'hC3, 1'b1);
        tx_valid = 1'b0;
        wait_cnt("t4_done_timeout", 0, 1);
        check("t4_rx", 32'(last_rx), 32'(exp_rx(8'hC3, 8'h81)));
        check("t4_rxv_cnt", 32'(n_rxv), 32'd1);
        check("t4_mosi_cap", 32'(mosi_cap), 32'hC3);
        repeat (4) tick();

        // back-to-back transactions, next byte offered at once
        slv_byte = 8'h24;
        clr_mon();
        offer(8'h11, 1'b1);
        tx_data = 8'h22;
        tx_last = 1'b1;
        wait_cnt("t5_done_timeout", 0, 1);
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check("t5_ready_low", 32'(n), 32'(SS_IDLE));
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tick();
        check("t5_ss_high", 32'(last_ss_run >= int'(SS_IDLE + 1)), 32'd1);
        wait_cnt("t5_done2_timeout", 0, 2);
        check("t5_rxv_cnt", 32'(n_rxv), 32'd2);
        check("t5_rx", 32'(last_rx), 32'(exp_rx(8'h22, 8'h24)));
        repeat (4) tick();

`ifdef SPI_MASTER_LOOPBACK_EN
        hold0 = 1'b1;
        clr_mon();
        offer(8'h96, 1'b1);
        tx_valid = 1'b0;
        wait_cnt("t6_done_timeout", 0, 1);
        check("t6_loopback", 32'(last_rx), 32'h96);
        hold0 = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
